// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped write-through cache: default
// geometry, the controller state encoding and small helper functions.
package cache_pkg;

  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_ADDR_WIDTH   = 10;
  localparam int DEF_INDEX_WIDTH  = 5;
  localparam int DEF_OFFSET_WIDTH = 2;
  localparam int COUNT_WIDTH      = 16;

  // Tag bits are whatever is left of the significant word address.
  function automatic int tag_width(input int addr_w, input int index_w, input int offset_w);
    return addr_w - index_w - offset_w;
  endfunction

  localparam int DEF_TAG_WIDTH = tag_width(DEF_ADDR_WIDTH, DEF_INDEX_WIDTH, DEF_OFFSET_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RD_MISS,
    WR_THRU,
    WR_DONE
  } state_t;

  // Performance counters stick at all-ones instead of wrapping.
  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] c);
    return (&c) ? c : c + COUNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/cache_storage.sv
// Tag, valid and data arrays of the direct-mapped cache. Reads are
// combinational; writes are either a whole refill line or a single word.
module cache_storage
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int INDEX_WIDTH  = DEF_INDEX_WIDTH,
  parameter int OFFSET_WIDTH = DEF_OFFSET_WIDTH,
  parameter int TAG_WIDTH    = DEF_TAG_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [INDEX_WIDTH-1:0]                index,
  input  logic [OFFSET_WIDTH-1:0]               offset,
  output logic                                  valid,
  output logic [TAG_WIDTH-1:0]                  tag,
  output logic [DATA_WIDTH-1:0]                 rd_word,
  input  logic                                  line_we,
  input  logic [TAG_WIDTH-1:0]                  line_tag,
  input  logic [(DATA_WIDTH<<OFFSET_WIDTH)-1:0] line_data,
  input  logic                                  word_we,
  input  logic [DATA_WIDTH-1:0]                 word_data
);

  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int WORDS = 1 << OFFSET_WIDTH;

  logic [LINES-1:0]      valid_bits;
  logic [TAG_WIDTH-1:0]  tag_mem  [LINES];
  logic [DATA_WIDTH-1:0] data_mem [LINES*WORDS];

  assign valid   = valid_bits[index];
  assign tag     = tag_mem[index];
  assign rd_word = data_mem[{index, offset}];

  // Valid bits: cleared by reset, set when a refill lands.
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_bits <= '0;
    end else if (line_we) begin
      valid_bits[index] <= 1'b1;
    end
  end

  // Tag and data writes: a refill replaces the whole line, a store hit one word.
  // NOTE: no reset on the tag/data arrays; the valid bits alone decide whether contents count.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_mem[index] <= line_tag;
      for (int w = 0; w < WORDS; w++) begin
        data_mem[{index, OFFSET_WIDTH'(w)}] <= line_data[w*DATA_WIDTH +: DATA_WIDTH];
      end
    end else if (word_we) begin
      data_mem[{index, offset}] <= word_data;
    end
  end

endmodule

// File: rtl/dm_cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache controller. Read hits
// return data in the same cycle; read misses refill a whole line; every store
// is written through to memory and retires in a single WR_DONE cycle.
module dm_cache_controller
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int INDEX_WIDTH  = DEF_INDEX_WIDTH,
  parameter int OFFSET_WIDTH = DEF_OFFSET_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  Mem_Read,
  input  logic                                  Mem_Write,
  input  logic [DATA_WIDTH-1:0]                 Word_address,
  input  logic [DATA_WIDTH-1:0]                 Data_In,
  output logic [DATA_WIDTH-1:0]                 Data_Out,
  output logic                                  stall,
  output logic                                  mem_rd_req,
  output logic                                  mem_wr_req,
  output logic [ADDR_WIDTH-1:0]                 mem_addr,
  output logic [DATA_WIDTH-1:0]                 mem_wdata,
  input  logic [(DATA_WIDTH<<OFFSET_WIDTH)-1:0] mem_rdata,
  input  logic                                  mem_ready,
  output logic [COUNT_WIDTH-1:0]                hit_count,
  output logic [COUNT_WIDTH-1:0]                miss_count
);

  localparam int TAG_WIDTH = tag_width(ADDR_WIDTH, INDEX_WIDTH, OFFSET_WIDTH);

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [OFFSET_WIDTH-1:0] offset;
  logic [INDEX_WIDTH-1:0]  index;
  logic [TAG_WIDTH-1:0]    tag;
  logic                    line_valid;
  logic [TAG_WIDTH-1:0]    line_tag;
  logic                    hit;
  logic                    wr_req;
  logic                    rd_req;
  logic                    line_we;
  logic                    word_we;
  logic                    refill_retry;
  logic                    unused_addr_hi;

  // Only the low ADDR_WIDTH bits of the CPU address are significant.
  assign addr           = Word_address[ADDR_WIDTH-1:0];
  assign unused_addr_hi = ^Word_address[DATA_WIDTH-1:ADDR_WIDTH];
  assign offset         = addr[OFFSET_WIDTH-1:0];
  assign index          = addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign tag            = addr[ADDR_WIDTH-1 -: TAG_WIDTH];

  assign hit    = line_valid && (line_tag == tag);
  assign wr_req = Mem_Write;               // read+write together is a write
  assign rd_req = Mem_Read && !Mem_Write;

  // A reset abandons any transaction, so a completion under reset writes nothing.
  assign line_we   = !rst && (state == RD_MISS) && mem_ready;
  assign word_we   = !rst && (state == WR_THRU) && mem_ready && hit;
  assign mem_wdata = Data_In;

  cache_storage #(
    .DATA_WIDTH  (DATA_WIDTH),
    .INDEX_WIDTH (INDEX_WIDTH),
    .OFFSET_WIDTH(OFFSET_WIDTH),
    .TAG_WIDTH   (TAG_WIDTH)
  ) u_storage (
    .clk      (clk),
    .rst      (rst),
    .index    (index),
    .offset   (offset),
    .valid    (line_valid),
    .tag      (line_tag),
    .rd_word  (Data_Out),
    .line_we  (line_we),
    .line_tag (tag),
    .line_data(mem_rdata),
    .word_we  (word_we),
    .word_data(Data_In)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; mem_ready only matters while a memory request is open.
  // NOTE: default assignment first so every path assigns and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (wr_req) begin
          state_next = WR_THRU;
        end else if (rd_req && !hit) begin
          state_next = RD_MISS;
        end
      end
      RD_MISS: if (mem_ready) state_next = IDLE;
      WR_THRU: if (mem_ready) state_next = WR_DONE;
      WR_DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs: stall and memory requests, all forced low while in reset.
  always_comb begin
    stall      = 1'b0;
    mem_rd_req = 1'b0;
    mem_wr_req = 1'b0;
    mem_addr   = addr;
    if (!rst) begin
      case (state)
        IDLE: stall = wr_req || (rd_req && !hit);
        RD_MISS: begin
          stall      = 1'b1;
          mem_rd_req = 1'b1;
          mem_addr   = {tag, index, {OFFSET_WIDTH{1'b0}}};
        end
        WR_THRU: begin
          stall      = 1'b1;
          mem_wr_req = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Counters: each request counts once at its IDLE lookup; the hit that
  // retires a refilled read is the same request and is not counted again.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count    <= '0;
      miss_count   <= '0;
      refill_retry <= 1'b0;
    end else begin
      refill_retry <= line_we;
      if ((state == IDLE) && !refill_retry && (wr_req || rd_req)) begin
        if (hit) begin
          hit_count <= sat_inc(hit_count);
        end else begin
          miss_count <= sat_inc(miss_count);
        end
      end
    end
  end

endmodule

// File: tb/tb_dm_cache_controller.sv
// Self-checking bench for dm_cache_controller: a transaction-level model of
// the cache and main memory predicts every cycle's outputs; one compare
// process checks them on the falling edge.
module tb_dm_cache_controller;

  logic         clk;
  logic         rst;
  logic         Mem_Read;
  logic         Mem_Write;
  logic [31:0]  Word_address;
  logic [31:0]  Data_In;
  logic [31:0]  Data_Out;
  logic         stall;
  logic         mem_rd_req;
  logic         mem_wr_req;
  logic [9:0]   mem_addr;
  logic [31:0]  mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;

  dm_cache_controller dut (
    .clk         (clk),
    .rst         (rst),
    .Mem_Read    (Mem_Read),
    .Mem_Write   (Mem_Write),
    .Word_address(Word_address),
    .Data_In     (Data_In),
    .Data_Out    (Data_Out),
    .stall       (stall),
    .mem_rd_req  (mem_rd_req),
    .mem_wr_req  (mem_wr_req),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .hit_count   (hit_count),
    .miss_count  (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: cache contents, main memory, counters.
  logic        m_valid [32];
  logic [2:0]  m_tag   [32];
  logic [31:0] m_data  [32][4];
  logic [31:0] main_mem[1024];
  logic [15:0] m_hit;
  logic [15:0] m_miss;

  // Per-cycle expectations consumed by the compare process.
  logic        chk_en = 1'b0;
  logic        exp_stall, exp_rd, exp_wr, exp_dv;
  logic [9:0]  exp_addr;
  logic [31:0] exp_wdata, exp_dout;

  // Observations of the current transaction for the pinned checks.
  int          obs_stall;
  logic [31:0] obs_dout;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", 32'(stall), 32'(exp_stall));
      check("mem_rd_req", 32'(mem_rd_req), 32'(exp_rd));
      check("mem_wr_req", 32'(mem_wr_req), 32'(exp_wr));
      if (exp_rd || exp_wr) check("mem_addr", 32'(mem_addr), 32'(exp_addr));
      if (exp_wr) check("mem_wdata", mem_wdata, exp_wdata);
      if (exp_dv) check("Data_Out", Data_Out, exp_dout);
      check("hit_count", 32'(hit_count), 32'(m_hit));
      check("miss_count", 32'(miss_count), 32'(m_miss));
    end
  end

  function automatic logic [15:0] sat(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  function automatic logic model_hit(input logic [9:0] a);
    return m_valid[a[6:2]] && (m_tag[a[6:2]] == a[9:7]);
  endfunction

  task automatic set_exp(input logic s, input logic rd, input logic wr, input logic [9:0] a,
                         input logic [31:0] wd, input logic dv, input logic [31:0] d);
    exp_stall = s;
    exp_rd    = rd;
    exp_wr    = wr;
    exp_addr  = a;
    exp_wdata = wd;
    exp_dv    = dv;
    exp_dout  = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    #1;
    if (stall === 1'b1) obs_stall++;
    obs_dout = Data_Out;
  endtask

  task automatic drive_addr(input logic [9:0] a);
    Word_address = {22'($urandom), a};
  endtask

  task automatic clear_model_valid();
    for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
  endtask

  task automatic apply_reset(input int cycles);
    rst = 1'b1; Mem_Read = 1'b1; Mem_Write = 1'b0; mem_ready = 1'b0;
    drive_addr(10'h010);
    for (int c = 0; c < cycles; c++) begin
      set_exp(1'b0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 32'h0);
      sample(); step();
      m_hit = 16'd0; m_miss = 16'd0;
      clear_model_valid();
    end
    rst = 1'b0; Mem_Read = 1'b0;
  endtask

  task automatic idle_cycle();
    logic [9:0] a;
    a = 10'($urandom);
    Mem_Read = 1'b0; Mem_Write = 1'b0; drive_addr(a); Data_In = $urandom;
    mem_ready = 1'($urandom);
    mem_rdata = {$urandom, $urandom, $urandom, $urandom};
    set_exp(1'b0, 1'b0, 1'b0, a, 32'h0, m_valid[a[6:2]], m_data[a[6:2]][a[1:0]]);
    sample(); step();
    mem_ready = 1'b0;
  endtask

  task automatic do_read(input logic [9:0] a, input int lat);
    logic [9:0] base;
    base = {a[9:2], 2'b00};
    obs_stall = 0;
    Mem_Read = 1'b1; Mem_Write = 1'b0; drive_addr(a); Data_In = $urandom; mem_ready = 1'b0;
    if (model_hit(a)) begin
      set_exp(1'b0, 1'b0, 1'b0, a, 32'h0, 1'b1, m_data[a[6:2]][a[1:0]]);
      sample(); step();
      m_hit = sat(m_hit);
    end else begin
      set_exp(1'b1, 1'b0, 1'b0, a, 32'h0, 1'b0, 32'h0);
      sample(); step();
      m_miss = sat(m_miss);
      mem_rdata = {main_mem[base+3], main_mem[base+2], main_mem[base+1], main_mem[base]};
      for (int c = 1; c <= lat; c++) begin
        mem_ready = (c == lat);
        set_exp(1'b1, 1'b1, 1'b0, base, 32'h0, 1'b0, 32'h0);
        sample(); step();
      end
      mem_ready = 1'b0;
      m_valid[a[6:2]] = 1'b1;
      m_tag[a[6:2]]   = a[9:7];
      for (int w = 0; w < 4; w++) m_data[a[6:2]][w] = main_mem[base + 10'(w)];
      set_exp(1'b0, 1'b0, 1'b0, a, 32'h0, 1'b1, m_data[a[6:2]][a[1:0]]);
      sample(); step();
    end
    Mem_Read = 1'b0;
  endtask

  task automatic do_write(input logic [9:0] a, input logic [31:0] d, input int lat, input logic both);
    logic h;
    obs_stall = 0;
    h = model_hit(a);
    Mem_Write = 1'b1; Mem_Read = both; drive_addr(a); Data_In = d; mem_ready = 1'b0;
    mem_rdata = {$urandom, $urandom, $urandom, $urandom};
    set_exp(1'b1, 1'b0, 1'b0, a, d, 1'b0, 32'h0);
    sample(); step();
    if (h) m_hit = sat(m_hit); else m_miss = sat(m_miss);
    for (int c = 1; c <= lat; c++) begin
      mem_ready = (c == lat);
      set_exp(1'b1, 1'b0, 1'b1, a, d, 1'b0, 32'h0);
      sample(); step();
    end
    mem_ready = 1'b0;
    main_mem[a] = d;
    if (h) m_data[a[6:2]][a[1:0]] = d;
    set_exp(1'b0, 1'b0, 1'b0, a, d, 1'b0, 32'h0);
    sample(); step();
    Mem_Write = 1'b0; Mem_Read = 1'b0;
  endtask

  // Read miss on a, one RD_MISS cycle, reset pulse, then a stale mem_ready.
  task automatic reset_in_rd_miss(input logic [9:0] a);
    Mem_Read = 1'b1; Mem_Write = 1'b0; drive_addr(a); mem_ready = 1'b0;
    set_exp(1'b1, 1'b0, 1'b0, a, 32'h0, 1'b0, 32'h0);
    sample(); step();
    m_miss = sat(m_miss);
    set_exp(1'b1, 1'b1, 1'b0, {a[9:2], 2'b00}, 32'h0, 1'b0, 32'h0);
    sample(); step();
    rst = 1'b1;
    set_exp(1'b0, 1'b0, 1'b0, a, 32'h0, 1'b0, 32'h0);
    sample(); step();
    m_hit = 16'd0; m_miss = 16'd0;
    clear_model_valid();
    rst = 1'b0; Mem_Read = 1'b0; mem_ready = 1'b1;
    mem_rdata = {$urandom, $urandom, $urandom, $urandom};
    set_exp(1'b0, 1'b0, 1'b0, a, 32'h0, 1'b0, 32'h0);
    sample(); step();
    mem_ready = 1'b0;
  endtask

  initial begin
    logic [9:0] a;
    for (int i = 0; i < 1024; i++) main_mem[i] = $urandom;
    main_mem[10'h010] = 32'd1;
    main_mem[10'h011] = 32'd2;
    main_mem[10'h012] = 32'd3;
    main_mem[10'h013] = 32'd4;
    clear_model_valid();
    m_hit = 16'd0; m_miss = 16'd0;
    rst = 1'b1; Mem_Read = 1'b0; Mem_Write = 1'b0; Word_address = 32'h0;
    Data_In = 32'h0; mem_rdata = '0; mem_ready = 1'b0;
    set_exp(1'b0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 32'h0);
    step();
    chk_en = 1'b1;
    apply_reset(2);
    check("reset_hit_count", 32'(hit_count), 32'd0);
    check("reset_miss_count", 32'(miss_count), 32'd0);

    // Cold read: line {4,3,2,1} after 3 cycles.
    do_read(10'h010, 3);
    check("cold_stall_cycles", obs_stall, 32'd4);
    check("cold_data", obs_dout, 32'd1);
    check("cold_miss_count", 32'(miss_count), 32'd1);

    // Same-line read hits at once.
    do_read(10'h013, 2);
    check("same_line_stall", obs_stall, 32'd0);
    check("same_line_data", obs_dout, 32'd4);
    check("same_line_hit_count", 32'(hit_count), 32'd1);

    // Write hit then read back.
    do_write(10'h012, 32'hDEADBEEF, 2, 1'b0);
    check("wr_hit_count", 32'(hit_count), 32'd2);
    do_read(10'h012, 2);
    check("wr_hit_readback", obs_dout, 32'hDEADBEEF);
    check("wr_hit_readback_stall", obs_stall, 32'd0);

    // Conflict miss on index 4.
    do_read(10'h090, 2);
    check("conflict_miss_count", 32'(miss_count), 32'd2);
    do_read(10'h010, 2);
    check("conflict_refetch_stall", obs_stall, 32'd3);

    // Write miss: memory only.
    do_write(10'h3FC, 32'h12345678, 1, 1'b0);
    check("wr_miss_count", 32'(miss_count), 32'd4);
    do_read(10'h3FC, 1);
    check("wr_miss_read_stall", obs_stall, 32'd2);
    check("wr_miss_read_data", obs_dout, 32'h12345678);

    // Read and write together behave as a write.
    do_write(10'h011, 32'hCAFEF00D, 2, 1'b1);
    do_read(10'h011, 1);
    check("both_as_write_data", obs_dout, 32'hCAFEF00D);

    // Reset during RD_MISS with a late mem_ready.
    reset_in_rd_miss(10'h090);
    check("rst_rdmiss_hit_count", 32'(hit_count), 32'd0);
    do_read(10'h010, 3);
    check("rst_rdmiss_refetch_stall", obs_stall, 32'd4);
    check("rst_rdmiss_refetch_data", obs_dout, 32'd1);
    check("rst_rdmiss_miss_count", 32'(miss_count), 32'd1);

    // Random traffic on a few tags and indices so hits and conflicts mix.
    for (int t = 0; t < 300; t++) begin
      a = {3'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 2'($urandom)};
      case ($urandom_range(0, 3))
        0: do_read(a, $urandom_range(1, 4));
        1: do_write(a, $urandom, $urandom_range(1, 4), 1'b0);
        2: do_write(a, $urandom, $urandom_range(1, 4), 1'b1);
        default: idle_cycle();
      endcase
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dm_cache_controller.md
DM_CACHE_CONTROLLER -- requirements
Module: dm_cache_controller

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning CPU word and memory word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, meaning significant word-address bits; higher bits are ignored.
REQ-003 SHALL have parameter INDEX_WIDTH, default 5, meaning 32 cache lines.
REQ-004 SHALL have parameter OFFSET_WIDTH, default 2, meaning 4 words per line; tag width is ADDR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH (3).
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1, meaning reset, synchronous and active-high.
REQ-007 SHALL have ports Mem_Read and Mem_Write, input, 1 each, meaning the CPU load and store requests.
REQ-008 SHALL have port Word_address, input, DATA_WIDTH, meaning the CPU word address: offset [1:0], index [6:2], tag [9:7].
REQ-009 SHALL have port Data_In, input, DATA_WIDTH, meaning the store data.
REQ-010 SHALL have port Data_Out, output, DATA_WIDTH, meaning the load data.
REQ-011 SHALL have port stall, output, 1, meaning freeze the CPU PC and hold the request.
REQ-012 SHALL have ports mem_rd_req and mem_wr_req, output, 1 each, meaning the main-memory line-read and word-write requests.
REQ-013 SHALL have port mem_addr, output, ADDR_WIDTH, meaning the memory address: line-aligned (offset 0) for reads, the word address for writes.
REQ-014 SHALL have port mem_wdata, output, DATA_WIDTH, meaning the write-through data.
REQ-015 SHALL have port mem_rdata, input, 4*DATA_WIDTH, meaning the refill line, with word 0 in the LSBs.
REQ-016 SHALL have port mem_ready, input, 1, meaning a one-cycle completion pulse for the outstanding request.
REQ-017 SHALL have ports hit_count and miss_count, output, 16 each, meaning saturating performance counters.

Function
REQ-018 SHALL implement a direct-mapped, write-through, no-write-allocate cache.
REQ-019 SHALL implement states IDLE, RD_MISS, WR_THRU and WR_DONE.
REQ-020 In IDLE, a read hit (valid and tag match) SHALL drive Data_Out combinationally in the same cycle with stall=0, and hit_count SHALL increment.
REQ-021 In IDLE, a read miss SHALL assert stall combinationally, go to RD_MISS and increment miss_count.
REQ-022 In RD_MISS, the block SHALL hold mem_rd_req=1 with mem_addr={tag,index,00} and stall=1.
REQ-023 On mem_ready in RD_MISS, the block SHALL write the whole line, set tag and valid, and return to IDLE; the held request then hits the next cycle (miss penalty = memory latency + 1 cycle).
REQ-024 In IDLE, Mem_Write SHALL assert stall combinationally, go to WR_THRU, and count hit or miss by tag lookup.
REQ-025 In WR_THRU, the block SHALL hold mem_wr_req=1, mem_addr=word address, mem_wdata=Data_In and stall=1.
REQ-026 On mem_ready in WR_THRU, the block SHALL update the cached word if the line hits (a miss leaves the cache unchanged) and go to WR_DONE.
REQ-027 WR_DONE SHALL drive stall=0 for exactly one cycle so the store retires, then go to IDLE unconditionally.
REQ-028 Mem_Read and Mem_Write asserted together SHALL be treated as a write.
REQ-029 With no request in IDLE, stall SHALL be 0, both memory requests SHALL be 0, and Data_Out SHALL equal the addressed cache word (don't-care).
REQ-030 mem_ready outside RD_MISS/WR_THRU SHALL be ignored.
REQ-031 mem_rd_req and mem_wr_req SHALL never be asserted together.
REQ-032 The counters SHALL hold at 16'hFFFF once reached, and SHALL count once per request, not once per stalled cycle.

Reset
REQ-033 While rst is high at a clock edge, the block SHALL go to IDLE and clear all valid bits and both counters; data and tag arrays are not cleared.
REQ-034 While rst is high, stall, mem_rd_req and mem_wr_req SHALL be 0.
REQ-035 A reset during RD_MISS or WR_THRU SHALL abandon the transaction; a mem_ready arriving later SHALL be ignored.

Structure
REQ-036 The state encoding, default widths and derived tag width SHALL live in the shared package cache_pkg.
REQ-037 The tag, valid and data arrays SHALL be a sub-module cache_storage with one-line write and word write ports; the FSM and counters SHALL stay in the top module.

Verification
REQ-038 The bench SHALL cover a cold read: after reset, read 0x010 with memory returning line {4,3,2,1} after 3 cycles -> stall for 4 cycles, Data_Out=1, miss_count=1.
REQ-039 The bench SHALL cover a same-line read: then read 0x013 -> stall=0 in the same cycle, Data_Out=4, hit_count=1.
REQ-040 The bench SHALL cover a write hit: write 0x012 with 0xDEADBEEF -> mem_wr_req with addr 0x012, one WR_DONE cycle with stall=0; a later read 0x012 hits with 0xDEADBEEF.
REQ-041 The bench SHALL cover a conflict miss: read 0x090 (same index, tag 1) -> refill, then read 0x010 misses again.
REQ-042 The bench SHALL cover a write miss: write 0x3FC -> memory write only; a later read 0x3FC misses.
REQ-043 The bench SHALL cover reset during RD_MISS: rst pulse, then a late mem_ready -> IDLE, stall=0, valid cleared, and the next read of 0x010 misses.
